// File: rtl/serial_mag_comp_pkg.sv
// Shared constants for the bit-serial magnitude comparator.
// State encodings and default widths.
package serial_mag_comp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_N     = 8;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/mag_comp_1bit.sv
// Single-bit magnitude comparator.
// Exactly one of L/G/E is high for any input pair.
module mag_comp_1bit (
    input  logic a,
    input  logic b,
    output logic L,
    output logic G,
    output logic E
);

    assign L = ~a & b;
    assign G = a & ~b;
    assign E = ~(a ^ b);

endmodule

// File: rtl/serial_mag_comp.sv
// Bit-serial N-bit magnitude comparator, operands MSB first.
// SERIAL_MAG_COMP_EARLY_DONE_EN: finish on the first unequal bit pair.
module serial_mag_comp
    import serial_mag_comp_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic bit_valid,
    input  logic a_bit,
    input  logic b_bit,
    output logic busy,
    output logic done,
    output logic L,
    output logic G,
    output logic E
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             decided_q, decided_d;
    logic             lt_q, lt_d;
    logic             gt_q, gt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             l_q, l_d;
    logic             g_q, g_d;
    logic             e_q, e_d;

    logic bit_l, bit_g, bit_e;
    logic lt_n, gt_n, dec_n;
    logic last_bit, finish;
    logic restart;

    mag_comp_1bit u_cmp (
        .a (a_bit),
        .b (b_bit),
        .L (bit_l),
        .G (bit_g),
        .E (bit_e)
    );

    // Only the first unequal pair may set lt/gt.
    assign lt_n     = lt_q | (~decided_q & bit_l);
    assign gt_n     = gt_q | (~decided_q & bit_g);
    assign dec_n    = decided_q | ~bit_e;
    assign last_bit = (cnt_q == LAST_CNT);

`ifdef SERIAL_MAG_COMP_EARLY_DONE_EN
    assign finish = last_bit | (~decided_q & ~bit_e);
`else
    assign finish = last_bit;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        decided_d = decided_q;
        lt_d      = lt_q;
        gt_d      = gt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        l_d       = l_q;
        g_d       = g_q;
        e_d       = e_q;
        restart   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                restart = start;
            end
            ST_RUN: begin
                if (start) begin
                    restart = 1'b1;
                end else if (bit_valid) begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    decided_d = dec_n;
                    lt_d      = lt_n;
                    gt_d      = gt_n;
                    if (finish) begin
                        state_d = ST_DONE;
                        l_d     = lt_n;
                        g_d     = gt_n;
                        e_d     = ~(lt_n | gt_n);
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                restart = start;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Start from any state aborts and re-arms the comparison.
        if (restart) begin
            state_d   = ST_RUN;
            cnt_d     = '0;
            decided_d = 1'b0;
            lt_d      = 1'b0;
            gt_d      = 1'b0;
            busy_d    = 1'b1;
            done_d    = 1'b0;
            l_d       = 1'b0;
            g_d       = 1'b0;
            e_d       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            lt_q      <= 1'b0;
            gt_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            l_q       <= 1'b0;
            g_q       <= 1'b0;
            e_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            decided_q <= decided_d;
            lt_q      <= lt_d;
            gt_q      <= gt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            l_q       <= l_d;
            g_q       <= g_d;
            e_q       <= e_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign L    = l_q;
    assign G    = g_q;
    assign E    = e_q;

endmodule
